// File: rtl/azadi_wb_tlul_pkg.sv
// azadi_wb_tlul_pkg: shared TL-UL opcodes, bridge FSM states and default error data
package azadi_wb_tlul_pkg;

    localparam logic [2:0] PUT_FULL    = 3'd0;
    localparam logic [2:0] PUT_PARTIAL = 3'd1;
    localparam logic [2:0] GET         = 3'd4;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

    // DRAIN is only reachable when the D-channel timeout is built in
    typedef enum logic [2:0] {
        IDLE,
        A_REQ,
        D_WAIT,
        ACK,
        DRAIN
    } bridge_state_e;

endpackage

// File: rtl/wb_tlul_timeout_ctr.sv
// wb_tlul_timeout_ctr: counts enabled cycles and flags the last one before the limit
module wb_tlul_timeout_ctr #(
    parameter int CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic expired_o
);

    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] cnt_q;

    // count cycles while enabled, restart from zero whenever cleared
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else cnt_q <= clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
    end

    assign expired_o = en_i && (cnt_q == W'(CYCLES - 1));

endmodule

// File: rtl/wb_tlul_host_bridge.sv
// wb_tlul_host_bridge: Wishbone classic slave to TL-UL host, one transaction in flight.
// Define WB_TIMEOUT_EN to bound the D-channel wait and drain late responses.
module wb_tlul_host_bridge
    import azadi_wb_tlul_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK      = 32'hFF00_0000,
    parameter logic [31:0] ERR_DATA       = DEFAULT_ERR_DATA,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        tl_a_valid_o,
    input  logic        tl_a_ready_i,
    output logic [2:0]  tl_a_opcode_o,
    output logic [31:0] tl_a_address_o,
    output logic [3:0]  tl_a_mask_o,
    output logic [31:0] tl_a_data_o,
    input  logic        tl_d_valid_i,
    output logic        tl_d_ready_o,
    input  logic [31:0] tl_d_data_i,
    input  logic        tl_d_error_i
);

    bridge_state_e state_q, state_d;
    logic [31:0]   adr_q, adr_d, dat_q, dat_d, rdata_q, rdata_d;
    logic [3:0]    sel_q, sel_d;
    logic          we_q, we_d, abort_q, abort_d, drain_q, drain_d;
    logic          timeout, in_win, unused_adr;

    assign in_win     = (wbs_adr_i & ADDR_MASK) == (BASE_ADDR & ADDR_MASK);
    assign unused_adr = ^adr_q[1:0];

`ifdef WB_TIMEOUT_EN
    wb_tlul_timeout_ctr #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .en_i      (state_q == D_WAIT),
        .clr_i     (state_q != D_WAIT),
        .expired_o (timeout)
    );
`else
    logic unused_timeout;
    assign timeout        = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // A-channel fields are driven only while the request is presented
    assign tl_a_valid_o   = state_q == A_REQ;
    assign tl_a_opcode_o  = !tl_a_valid_o ? 3'd0 : !we_q ? GET : (sel_q == 4'hF) ? PUT_FULL : PUT_PARTIAL;
    assign tl_a_address_o = tl_a_valid_o ? {adr_q[31:2], 2'b00} : '0;
    assign tl_a_mask_o    = !tl_a_valid_o ? 4'h0 : (!we_q && sel_q == 4'h0) ? 4'hF : sel_q;
    assign tl_a_data_o    = tl_a_valid_o ? dat_q : '0;
    assign tl_d_ready_o   = (state_q == D_WAIT) || (state_q == DRAIN);
    assign wbs_ack_o      = (state_q == ACK) && !abort_q;
    assign wbs_dat_o      = rdata_q;

    // transfer sequencing; a dropped cyc only suppresses the ack, TL still completes
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        abort_d = abort_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: if (wbs_cyc_i && wbs_stb_i) begin
                abort_d = 1'b0;
                if (in_win) begin
                    adr_d   = wbs_adr_i;
                    dat_d   = wbs_dat_i;
                    sel_d   = wbs_sel_i;
                    we_d    = wbs_we_i;
                    state_d = A_REQ;
                end else begin
                    rdata_d = wbs_we_i ? rdata_q : ERR_DATA;
                    state_d = ACK;
                end
            end
            A_REQ: begin
                abort_d = abort_q || !wbs_cyc_i;
                state_d = tl_a_ready_i ? D_WAIT : A_REQ;
            end
            D_WAIT: begin
                abort_d = abort_q || !wbs_cyc_i;
                if (tl_d_valid_i) begin
                    rdata_d = we_q ? rdata_q : tl_d_error_i ? ERR_DATA : tl_d_data_i;
                    state_d = ACK;
                end else if (timeout) begin
                    rdata_d = we_q ? rdata_q : ERR_DATA;
                    drain_d = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                drain_d = 1'b0;
                state_d = drain_q ? DRAIN : IDLE;
            end
            DRAIN: state_d = tl_d_valid_i ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    // state and transfer registers, cleared immediately by reset
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            abort_q <= 1'b0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            abort_q <= abort_d;
            drain_q <= drain_d;
        end
    end

endmodule

// File: tb/tb_wb_tlul_host_bridge.sv
// tb_wb_tlul_host_bridge: directed self-checking bench for the Wishbone to TL-UL bridge
module tb_wb_tlul_host_bridge;

    logic        clk = 1'b0, rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack, a_valid, d_ready;
    logic [31:0] rdat, a_address, a_data;
    logic [2:0]  a_opcode;
    logic [3:0]  a_mask;
    logic        a_ready = 1'b0, d_valid = 1'b0, d_error = 1'b0;
    logic [31:0] d_data = '0;
    int          checks = 0, errors = 0;

    wb_tlul_host_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .wbs_cyc_i      (cyc),
        .wbs_stb_i      (stb),
        .wbs_we_i       (we),
        .wbs_sel_i      (sel),
        .wbs_adr_i      (adr),
        .wbs_dat_i      (wdat),
        .wbs_ack_o      (ack),
        .wbs_dat_o      (rdat),
        .tl_a_valid_o   (a_valid),
        .tl_a_ready_i   (a_ready),
        .tl_a_opcode_o  (a_opcode),
        .tl_a_address_o (a_address),
        .tl_a_mask_o    (a_mask),
        .tl_a_data_o    (a_data),
        .tl_d_valid_i   (d_valid),
        .tl_d_ready_o   (d_ready),
        .tl_d_data_i    (d_data),
        .tl_d_error_i   (d_error)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wb_req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    endtask

    task automatic wb_idle;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        checks++;
        if ({ack, a_valid, d_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_handshakes got %b want 000", {ack, a_valid, d_ready});
        end
        checks++;
        if ({rdat, a_opcode, a_address, a_mask, a_data} !== '0) begin
            errors++;
            $display("FAIL reset_data got dat=%h op=%0d adr=%h mask=%h wdata=%h want all 0", rdat, a_opcode, a_address, a_mask, a_data);
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_read;
        wb_req(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        tick;
        checks++;
        if ({a_valid, a_opcode, a_address, a_mask, ack} !== {1'b1, 3'd4, 32'h3000_0010, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL read_a got v=%b op=%0d adr=%h mask=%h ack=%b want 1 4 30000010 f 0", a_valid, a_opcode, a_address, a_mask, ack);
        end
        a_ready = 1'b1;
        tick;
        checks++;
        if ({a_valid, d_ready, ack} !== 3'b010) begin
            errors++;
            $display("FAIL read_dwait got a_valid/d_ready/ack=%b want 010", {a_valid, d_ready, ack});
        end
        a_ready = 1'b0; d_valid = 1'b1; d_data = 32'h1234_5678;
        tick;
        checks++;
        if ({ack, rdat, d_ready} !== {1'b1, 32'h1234_5678, 1'b0}) begin
            errors++;
            $display("FAIL read_ack got ack=%b dat=%h d_ready=%b want 1 12345678 0", ack, rdat, d_ready);
        end
        d_valid = 1'b0;
        wb_idle;
        tick;
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL read_ack_single got ack=%b want 0", ack);
        end
    endtask

    task automatic test_read_sel0;
        wb_req(1'b0, 32'h3000_0013, 32'h0, 4'h0);
        tick;
        checks++;
        if ({a_opcode, a_address, a_mask} !== {3'd4, 32'h3000_0010, 4'hF}) begin
            errors++;
            $display("FAIL get_sel0 got op=%0d adr=%h mask=%h want 4 30000010 f", a_opcode, a_address, a_mask);
        end
        a_ready = 1'b1;
        tick;
        a_ready = 1'b0; d_valid = 1'b1; d_data = 32'h0000_00A5;
        tick;
        d_valid = 1'b0;
        wb_idle;
        tick;
    endtask

    task automatic test_write(input logic [3:0] s, input logic [31:0] d, input logic [2:0] exp_op);
        wb_req(1'b1, 32'h3000_0200, d, s);
        tick;
        checks++;
        if ({a_valid, a_opcode, a_mask, a_data} !== {1'b1, exp_op, s, d}) begin
            errors++;
            $display("FAIL write_a got v=%b op=%0d mask=%h data=%h want 1 %0d %h %h", a_valid, a_opcode, a_mask, a_data, exp_op, s, d);
        end
        a_ready = 1'b1;
        tick;
        a_ready = 1'b0; d_valid = 1'b1; d_data = 32'h0;
        tick;
        checks++;
        if ({ack, rdat} !== {1'b1, 32'h0000_00A5}) begin
            errors++;
            $display("FAIL write_ack got ack=%b dat=%h want 1 000000a5", ack, rdat);
        end
        d_valid = 1'b0;
        wb_idle;
        tick;
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL write_ack_single got ack=%b want 0", ack);
        end
    endtask

    task automatic test_out_of_window;
        wb_req(1'b0, 32'h4000_0000, 32'h0, 4'hF);
        tick;
        checks++;
        if ({a_valid, ack, rdat} !== {1'b0, 1'b1, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL oow_read got a_valid=%b ack=%b dat=%h want 0 1 deadbeef", a_valid, ack, rdat);
        end
        wb_idle;
        tick;
        checks++;
        if ({a_valid, ack} !== 2'b00) begin
            errors++;
            $display("FAIL oow_after got a_valid/ack=%b want 00", {a_valid, ack});
        end
    endtask

    task automatic test_stall_error;
        wb_req(1'b0, 32'h30AB_CD04, 32'h0, 4'h6);
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++;
            if ({a_valid, a_opcode, a_address, a_mask} !== {1'b1, 3'd4, 32'h30AB_CD04, 4'h6}) begin
                errors++;
                $display("FAIL stall_a%0d got v=%b op=%0d adr=%h mask=%h want 1 4 30abcd04 6", i, a_valid, a_opcode, a_address, a_mask);
            end
        end
        a_ready = 1'b1;
        tick;
        a_ready = 1'b0; d_valid = 1'b1; d_error = 1'b1; d_data = 32'h5555_5555;
        tick;
        checks++;
        if ({ack, rdat} !== {1'b1, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL derror got ack=%b dat=%h want 1 deadbeef", ack, rdat);
        end
        d_valid = 1'b0; d_error = 1'b0;
        wb_idle;
        tick;
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL derror_single got ack=%b want 0", ack);
        end
    endtask

    task automatic test_abort;
        wb_req(1'b0, 32'h3000_0020, 32'h0, 4'hF);
        tick;
        a_ready = 1'b1;
        tick;
        a_ready = 1'b0;
        wb_idle;
        tick;
        checks++;
        if (d_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_dwait got d_ready=%b want 1", d_ready);
        end
        d_valid = 1'b1; d_data = 32'h0BAD_F00D;
        tick;
        checks++;
        if ({ack, d_ready} !== 2'b00) begin
            errors++;
            $display("FAIL abort_noack got ack/d_ready=%b want 00", {ack, d_ready});
        end
        d_valid = 1'b0;
        tick;
        wb_req(1'b0, 32'h3000_0030, 32'h0, 4'hF);
        tick;
        checks++;
        if ({a_valid, a_address} !== {1'b1, 32'h3000_0030}) begin
            errors++;
            $display("FAIL abort_next_a got v=%b adr=%h want 1 30000030", a_valid, a_address);
        end
        a_ready = 1'b1;
        tick;
        a_ready = 1'b0; d_valid = 1'b1; d_data = 32'hCAFE_0001;
        tick;
        checks++;
        if ({ack, rdat} !== {1'b1, 32'hCAFE_0001}) begin
            errors++;
            $display("FAIL abort_next_ack got ack=%b dat=%h want 1 cafe0001", ack, rdat);
        end
        d_valid = 1'b0;
        wb_idle;
        tick;
    endtask

    task automatic test_reset_mid;
        wb_req(1'b0, 32'h3000_0040, 32'h0, 4'hF);
        tick;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({a_valid, d_ready, ack, rdat} !== {3'b000, 32'h0}) begin
            errors++;
            $display("FAIL reset_mid got v=%b dr=%b ack=%b dat=%h want 0 0 0 0", a_valid, d_ready, ack, rdat);
        end
        wb_idle;
        tick;
        rst = 1'b0;
        tick;
    endtask

`ifdef WB_TIMEOUT_EN
    task automatic test_timeout;
        int n = 0;
        wb_req(1'b0, 32'h3000_0044, 32'h0, 4'hF);
        tick;
        a_ready = 1'b1;
        tick;
        a_ready = 1'b0;
        while (ack !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        checks++;
        if ({n, rdat} !== {32'd16, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL timeout_ack got cycles=%0d dat=%h want 16 deadbeef", n, rdat);
        end
        wb_idle;
        tick;
        wb_req(1'b0, 32'h3000_0050, 32'h0, 4'hF);
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if ({a_valid, ack, d_ready} !== 3'b001) begin
                errors++;
                $display("FAIL drain_stall%0d got v/ack/dr=%b want 001", i, {a_valid, ack, d_ready});
            end
        end
        d_valid = 1'b1; d_data = 32'h1111_1111;
        tick;
        d_valid = 1'b0;
        tick;
        checks++;
        if ({a_valid, a_address} !== {1'b1, 32'h3000_0050}) begin
            errors++;
            $display("FAIL drain_resume got v=%b adr=%h want 1 30000050", a_valid, a_address);
        end
        a_ready = 1'b1;
        tick;
        a_ready = 1'b0; d_valid = 1'b1; d_data = 32'h0000_0077;
        tick;
        checks++;
        if ({ack, rdat} !== {1'b1, 32'h0000_0077}) begin
            errors++;
            $display("FAIL drain_next_ack got ack=%b dat=%h want 1 00000077", ack, rdat);
        end
        d_valid = 1'b0;
        wb_idle;
        tick;
    endtask
`endif

    initial begin
        test_reset;
        test_read;
        test_read_sel0;
        test_write(4'b0011, 32'hAABB_CCDD, 3'd1);
        test_write(4'hF, 32'h0102_0304, 3'd0);
        test_out_of_window;
        test_stall_error;
        test_abort;
        test_reset_mid;
`ifdef WB_TIMEOUT_EN
        test_timeout;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
